smart_mac_mr: RTL and testbench
===============================

# smart_mac_mr

Multi-region successor to the single-region SMART memory access controller. Sits between the openMSP430 data-memory read path and the core. Guards up to 16 protected key regions, each owned by one code region that may only be entered at its first address. A violation blanks read data in the same cycle and fires a stretched device reset; the cause is latched and counted for post-mortem inspection.

## Interface
Parameters:
- NUM_REGIONS, 2: number of protected regions, 1..16.
- ADDR_W, 16: width of `mem_addr`.
- RST_CYCLES, 4: reset pulse length in cycles, 1..255.
- KEY_LO, packed NUM_REGIONS×16: low bound of key region i, in bits [16i+15:16i].
- KEY_HI, packed NUM_REGIONS×16: high bound of key region i, inclusive.
- CODE_LO, packed NUM_REGIONS×16: entry point and low bound of code region i.
- CODE_HI, packed NUM_REGIONS×16: high bound of code region i, inclusive.

Ports:
- mclk  in  1  clock; the block's single clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_en  in  1  valid data-memory access this cycle.
- mem_addr  in  ADDR_W  data-memory address.
- mem_din  in  16  read data from memory.
- ins_addr  in  16  current instruction pointer.
- viol_clr  in  1  clears `viol_valid`, `viol_region` and `viol_type`.
- disable_debug  in  1  present only with SMART_MAC_DEBUG_BYPASS_EN.
- mem_dout  out  16  read data to the core, masked on violation.
- in_safe_area  out  NUM_REGIONS  per-region INSIDE state.
- reset  out  1  device reset request, active high.
- viol_valid  out  1  sticky flag: a violation has been captured.
- viol_region  out  4  index of the captured region.
- viol_type  out  2  captured cause: bit0 = data access, bit1 = illegal entry.
- viol_count  out  8  saturating count of violations.

## Operation
Per-region terms, evaluated combinationally for region i:
- `pc_in[i]` = CODE_LO[i] ≤ ins_addr ≤ CODE_HI[i].
- `entry[i]` = (ins_addr == CODE_LO[i]).
- `key_hit[i]` = mem_en & (KEY_LO[i] ≤ mem_addr ≤ KEY_HI[i]). `mem_addr` is zero-extended to 16 bits.
- `auth[i]` = (inside[i] & pc_in[i]) | entry[i].

Violation terms:
- `data_v[i]` = key_hit[i] & ~auth[i].
- `entry_v[i]` = pc_in[i] & ~entry[i] & ~inside[i], i.e. the code region was reached other than through its entry point.
- `any_v` = OR over all data_v | entry_v, gated off while the FSM is in HOLD.
- `mem_dout` = 16'h0 when any_v or `reset` is high; otherwise it equals mem_din. This path is combinational, so masking happens in the same cycle as the violation.

Region state (one bit per region, update priority top to bottom):
- Reset: OUTSIDE.
- FSM in HOLD: OUTSIDE.
- entry[i]: INSIDE.
- ~pc_in[i]: OUTSIDE.
- Otherwise: hold.

Reset FSM:
- IDLE: on any_v, go to HOLD and load the counter with RST_CYCLES-1.
- HOLD: `reset` is high. The counter decrements each cycle; at 0, return to IDLE.

Violation capture on any_v in IDLE:
- `viol_region` = lowest violating index.
- `viol_type` = {entry_v, data_v} of that region.
- `viol_valid` set to 1.
- `viol_count` += 1, saturating at 255.

Clear and overwrite rules:
- If an earlier capture is still valid, a new one overwrites it.
- `viol_clr` clears valid, region and type the next cycle. It does not touch `viol_count`.
- If `viol_clr` and a capture fall on the same edge, the capture wins.

Overlapping regions are legal; each region is evaluated independently.

## Timing
- Reset values: every region OUTSIDE, FSM IDLE, reset=0, viol_valid=0, viol_region=0, viol_type=0, viol_count=0. `mem_dout` follows `mem_din` after reset.
- A violation detected in cycle N drives `reset` high from cycle N+1 through N+RST_CYCLES inclusive.
- Data is masked combinationally in cycle N and stays masked during HOLD.
- Capture registers update at the edge ending cycle N.
- A region becomes INSIDE at the edge after `entry`. In the entry cycle itself, access is already authorised through the `entry` term of `auth`.
- Violations during HOLD are ignored: no capture, no count, no extension of the pulse.
- Asserting `reset_n` low mid-HOLD aborts the pulse immediately and clears all state.

## Configuration
SMART_MAC_DEBUG_BYPASS_EN:
- Defined: port `disable_debug` exists. While it is high, `reset` is forced to 0 and `mem_dout` is never masked. Detection, capture and counting still run.
- Undefined: the port is absent and protection cannot be bypassed.

## Test plan
- Region 0 with CODE 0x0100–0x01FF and KEY 0x0200–0x020F. ins_addr steps 0x0100 then 0x0102, mem read at 0x0204 -> data passes, no reset, in_safe_area[0]=1.
- ins_addr 0x0050, mem read at 0x0204 -> mem_dout=0 in the same cycle, `reset` high for exactly 4 cycles (RST_CYCLES=4), viol_region=0, viol_type=2'b01, viol_count=1.
- Jump directly to ins_addr 0x0120 -> viol_type=2'b10 and a reset pulse.
- Region 0 and region 1 violate in the same cycle -> viol_region=0. A second violation during HOLD -> viol_count unchanged and the pulse is not extended.
- 300 spaced violations -> viol_count saturates at 255. `viol_clr` clears viol_valid but keeps the count.
- reset_n pulled low in the 2nd HOLD cycle -> `reset` drops immediately and all outputs return to their reset values. With the macro defined and disable_debug=1, the same stimulus as the second scenario gives no reset and unmasked data, but viol_valid=1.

Source files
------------

// File: rtl/smart_mac_mr.sv
// smart_mac_mr: multi-region memory access controller for the openMSP430
// data-memory read path. Each region pairs a key range with a code range that
// may only be entered at its first address. Violations blank read data in the
// same cycle, fire a stretched reset pulse and are latched for post-mortem.
// Optional feature macro: SMART_MAC_DEBUG_BYPASS_EN adds the disable_debug
// input, which suppresses the reset pulse and the data masking.
module smart_mac_mr #(
    parameter int NUM_REGIONS = 2,
    parameter int ADDR_W      = 16,
    parameter int RST_CYCLES  = 4,
    parameter logic [NUM_REGIONS*16-1:0] KEY_LO  = {16'h0400, 16'h0200},
    parameter logic [NUM_REGIONS*16-1:0] KEY_HI  = {16'h040F, 16'h020F},
    parameter logic [NUM_REGIONS*16-1:0] CODE_LO = {16'h0300, 16'h0100},
    parameter logic [NUM_REGIONS*16-1:0] CODE_HI = {16'h03FF, 16'h01FF}
) (
    input  logic                   mclk,
    input  logic                   reset_n,
    input  logic                   mem_en,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [15:0]            mem_din,
    input  logic [15:0]            ins_addr,
    input  logic                   viol_clr,
`ifdef SMART_MAC_DEBUG_BYPASS_EN
    input  logic                   disable_debug,
`endif
    output logic [15:0]            mem_dout,
    output logic [NUM_REGIONS-1:0] in_safe_area,
    output logic                   reset,
    output logic                   viol_valid,
    output logic [3:0]             viol_region,
    output logic [1:0]             viol_type,
    output logic [7:0]             viol_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                 state_q;
    logic [7:0]             cnt_q;
    logic                   reset_q;
    logic [NUM_REGIONS-1:0] inside_q;
    logic [NUM_REGIONS-1:0] inside_d;
    logic                   viol_valid_q;
    logic [3:0]             viol_region_q;
    logic [1:0]             viol_type_q;
    logic [7:0]             viol_count_q;

    logic [15:0]            addr16_s;
    logic [NUM_REGIONS-1:0] pc_in_s;
    logic [NUM_REGIONS-1:0] entry_s;
    logic [NUM_REGIONS-1:0] key_hit_s;
    logic [NUM_REGIONS-1:0] auth_s;
    logic [NUM_REGIONS-1:0] data_v_s;
    logic [NUM_REGIONS-1:0] entry_v_s;
    logic                   any_v_s;
    logic [3:0]             first_idx_s;
    logic [1:0]             first_type_s;
    logic                   bypass_s;

    assign addr16_s = 16'(mem_addr);

`ifdef SMART_MAC_DEBUG_BYPASS_EN
    assign bypass_s = disable_debug;
`else
    assign bypass_s = 1'b0;
`endif

    // Per-region address decode and violation terms.
    always_comb begin
        pc_in_s   = '0;
        entry_s   = '0;
        key_hit_s = '0;
        auth_s    = '0;
        data_v_s  = '0;
        entry_v_s = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            pc_in_s[i]   = (ins_addr >= CODE_LO[16*i +: 16]) && (ins_addr <= CODE_HI[16*i +: 16]);
            entry_s[i]   = (ins_addr == CODE_LO[16*i +: 16]);
            key_hit_s[i] = mem_en && (addr16_s >= KEY_LO[16*i +: 16]) && (addr16_s <= KEY_HI[16*i +: 16]);
            auth_s[i]    = (inside_q[i] && pc_in_s[i]) || entry_s[i];
            data_v_s[i]  = key_hit_s[i] && !auth_s[i];
            entry_v_s[i] = pc_in_s[i] && !entry_s[i] && !inside_q[i];
        end
        // Violations seen while the reset pulse is running are ignored.
        any_v_s = (|(data_v_s | entry_v_s)) && (state_q == ST_IDLE);
    end

    // Lowest violating region wins the capture; scan downward so it lands last.
    always_comb begin
        first_idx_s  = 4'h0;
        first_type_s = 2'b00;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            first_idx_s  = (data_v_s[i] || entry_v_s[i]) ? 4'(i) : first_idx_s;
            first_type_s = (data_v_s[i] || entry_v_s[i]) ? {entry_v_s[i], data_v_s[i]} : first_type_s;
        end
    end

    // Next INSIDE/OUTSIDE state of each region.
    always_comb begin
        inside_d = inside_q;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (state_q == ST_HOLD) begin
                inside_d[i] = 1'b0;
            end else if (entry_s[i]) begin
                inside_d[i] = 1'b1;
            end else if (!pc_in_s[i]) begin
                inside_d[i] = 1'b0;
            end else begin
                inside_d[i] = inside_q[i];
            end
        end
    end

    // Region state register.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            inside_q <= '0;
        end else begin
            inside_q <= inside_d;
        end
    end

    // Reset-pulse FSM: a violation in IDLE holds reset high for RST_CYCLES cycles.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h00;
            reset_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_v_s) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= 8'(RST_CYCLES - 1);
                        reset_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'h00) begin
                        state_q <= ST_IDLE;
                        reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'h01;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 8'h00;
                    reset_q <= 1'b0;
                end
            endcase
        end
    end

    // Violation capture; a new capture beats a simultaneous clear, count saturates.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            viol_valid_q  <= 1'b0;
            viol_region_q <= 4'h0;
            viol_type_q   <= 2'b00;
            viol_count_q  <= 8'h00;
        end else if (any_v_s) begin
            viol_valid_q  <= 1'b1;
            viol_region_q <= first_idx_s;
            viol_type_q   <= first_type_s;
            if (viol_count_q != 8'hFF) begin
                viol_count_q <= viol_count_q + 8'h01;
            end
        end else if (viol_clr) begin
            viol_valid_q  <= 1'b0;
            viol_region_q <= 4'h0;
            viol_type_q   <= 2'b00;
        end
    end

    assign mem_dout     = ((any_v_s || reset_q) && !bypass_s) ? 16'h0000 : mem_din;
    assign reset        = reset_q && !bypass_s;
    assign in_safe_area = inside_q;
    assign viol_valid   = viol_valid_q;
    assign viol_region  = viol_region_q;
    assign viol_type    = viol_type_q;
    assign viol_count   = viol_count_q;

endmodule

// File: tb/tb_smart_mac_mr.sv
// Directed self-checking bench for smart_mac_mr (two regions, RST_CYCLES=4).
// Region 0: code 0x0100-0x01FF, key 0x0200-0x020F.
// Region 1: code 0x0300-0x03FF, key 0x0400-0x040F.
module tb_smart_mac_mr;

    logic        mclk;
    logic        reset_n;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] ins_addr;
    logic        viol_clr;
    logic [15:0] mem_dout;
    logic [1:0]  in_safe_area;
    logic        reset;
    logic        viol_valid;
    logic [3:0]  viol_region;
    logic [1:0]  viol_type;
    logic [7:0]  viol_count;
`ifdef SMART_MAC_DEBUG_BYPASS_EN
    logic        disable_debug;
`endif

    int n_checks;
    int n_fail;

    smart_mac_mr #(
        .NUM_REGIONS(2),
        .ADDR_W     (16),
        .RST_CYCLES (4),
        .KEY_LO     ({16'h0400, 16'h0200}),
        .KEY_HI     ({16'h040F, 16'h020F}),
        .CODE_LO    ({16'h0300, 16'h0100}),
        .CODE_HI    ({16'h03FF, 16'h01FF})
    ) dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .ins_addr     (ins_addr),
        .viol_clr     (viol_clr),
`ifdef SMART_MAC_DEBUG_BYPASS_EN
        .disable_debug(disable_debug),
`endif
        .mem_dout     (mem_dout),
        .in_safe_area (in_safe_area),
        .reset        (reset),
        .viol_valid   (viol_valid),
        .viol_region  (viol_region),
        .viol_type    (viol_type),
        .viol_count   (viol_count)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ins, input logic en, input logic [15:0] addr,
                         input logic [15:0] din);
        ins_addr = ins;
        mem_en   = en;
        mem_addr = addr;
        mem_din  = din;
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Called in cycle N+1 after a violation in cycle N; inputs are made idle.
    task automatic expect_pulse(input string tag);
        drive(16'h0050, 1'b0, 16'h0000, 16'h7777);
        for (int k = 0; k < 4; k++) begin
            check_eq({tag, "_rst_hi"}, {31'd0, reset}, 32'd1);
            check_eq({tag, "_masked"}, {16'd0, mem_dout}, 32'd0);
            tick();
        end
        check_eq({tag, "_rst_lo"}, {31'd0, reset}, 32'd0);
        check_eq({tag, "_unmask"}, {16'd0, mem_dout}, 32'h7777);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        viol_clr = 1'b0;
`ifdef SMART_MAC_DEBUG_BYPASS_EN
        disable_debug = 1'b0;
`endif
        drive(16'h0000, 1'b0, 16'h0000, 16'hA5A5);
        tick();
        tick();

        // Reset values
        check_eq("rst_reset", {31'd0, reset}, 32'd0);
        check_eq("rst_valid", {31'd0, viol_valid}, 32'd0);
        check_eq("rst_region", {28'd0, viol_region}, 32'd0);
        check_eq("rst_type", {30'd0, viol_type}, 32'd0);
        check_eq("rst_count", {24'd0, viol_count}, 32'd0);
        check_eq("rst_safe", {30'd0, in_safe_area}, 32'd0);
        check_eq("rst_dout", {16'd0, mem_dout}, 32'hA5A5);
        reset_n = 1'b1;
        tick();

        // Legal entry into region 0, key read authorised via entry term
        drive(16'h0100, 1'b1, 16'h0204, 16'h1111);
        #1 check_eq("entry_dout", {16'd0, mem_dout}, 32'h1111);
        tick();
        check_eq("entry_safe", {30'd0, in_safe_area}, 32'd1);
        drive(16'h0102, 1'b1, 16'h0204, 16'h1234);
        #1 check_eq("inside_dout", {16'd0, mem_dout}, 32'h1234);
        tick();
        check_eq("inside_reset", {31'd0, reset}, 32'd0);
        check_eq("inside_valid", {31'd0, viol_valid}, 32'd0);
        check_eq("inside_safe", {30'd0, in_safe_area}, 32'd1);

        // Data violation from outside
        drive(16'h0050, 1'b1, 16'h0204, 16'h5555);
        #1 check_eq("dv_mask_now", {16'd0, mem_dout}, 32'd0);
        tick();
        check_eq("dv_valid", {31'd0, viol_valid}, 32'd1);
        check_eq("dv_region", {28'd0, viol_region}, 32'd0);
        check_eq("dv_type", {30'd0, viol_type}, 32'd1);
        check_eq("dv_count", {24'd0, viol_count}, 32'd1);
        check_eq("dv_safe", {30'd0, in_safe_area}, 32'd0);
        expect_pulse("dv");

        // Illegal entry into the middle of region 0
        drive(16'h0120, 1'b0, 16'h0000, 16'h2222);
        #1 check_eq("ev_mask_now", {16'd0, mem_dout}, 32'd0);
        tick();
        check_eq("ev_type", {30'd0, viol_type}, 32'd2);
        check_eq("ev_region", {28'd0, viol_region}, 32'd0);
        check_eq("ev_count", {24'd0, viol_count}, 32'd2);
        expect_pulse("ev");

        // Legal entry into region 1 leaves region 0
        drive(16'h0300, 1'b0, 16'h0000, 16'h0000);
        tick();
        check_eq("r1_safe", {30'd0, in_safe_area}, 32'd2);

        // Both regions violate together: region 1 via key read, region 0 via... lowest index wins
        drive(16'h0150, 1'b1, 16'h0404, 16'h3333);
        tick();
        check_eq("both_region", {28'd0, viol_region}, 32'd0);
        check_eq("both_type", {30'd0, viol_type}, 32'd2);
        check_eq("both_count", {24'd0, viol_count}, 32'd3);
        // Keep violating throughout HOLD: ignored, pulse not extended
        ins_addr = 16'h0050;
        mem_en   = 1'b1;
        mem_addr = 16'h0404;
        mem_din  = 16'h7777;
        for (int k = 0; k < 4; k++) begin
            check_eq("hold_rst_hi", {31'd0, reset}, 32'd1);
            tick();
        end
        check_eq("hold_rst_lo", {31'd0, reset}, 32'd0);
        check_eq("hold_count", {24'd0, viol_count}, 32'd3);
        drive(16'h0050, 1'b0, 16'h0000, 16'h0000);
        tick();
        check_eq("hold_count2", {24'd0, viol_count}, 32'd3);

        // Clear keeps count
        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        check_eq("clr_valid", {31'd0, viol_valid}, 32'd0);
        check_eq("clr_type", {30'd0, viol_type}, 32'd0);
        check_eq("clr_count", {24'd0, viol_count}, 32'd3);

        // Capture beats a simultaneous clear
        viol_clr = 1'b1;
        drive(16'h0050, 1'b1, 16'h0404, 16'h0000);
        tick();
        viol_clr = 1'b0;
        check_eq("cw_valid", {31'd0, viol_valid}, 32'd1);
        check_eq("cw_region", {28'd0, viol_region}, 32'd1);
        check_eq("cw_type", {30'd0, viol_type}, 32'd1);
        check_eq("cw_count", {24'd0, viol_count}, 32'd4);
        expect_pulse("cw");

        // 300 spaced violations saturate the counter
        for (int v = 0; v < 300; v++) begin
            drive(16'h0050, 1'b1, 16'h0204, 16'h0000);
            tick();
            drive(16'h0050, 1'b0, 16'h0000, 16'h0000);
            repeat (4) tick();
        end
        check_eq("sat_count", {24'd0, viol_count}, 32'd255);
        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        check_eq("sat_clr_valid", {31'd0, viol_valid}, 32'd0);
        check_eq("sat_clr_count", {24'd0, viol_count}, 32'd255);

        // reset_n asserted in the second HOLD cycle
        drive(16'h0050, 1'b1, 16'h0204, 16'h0000);
        tick();
        drive(16'h0050, 1'b0, 16'h0000, 16'h4444);
        tick();
        check_eq("abort_pre", {31'd0, reset}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_reset", {31'd0, reset}, 32'd0);
        check_eq("abort_count", {24'd0, viol_count}, 32'd0);
        check_eq("abort_valid", {31'd0, viol_valid}, 32'd0);
        check_eq("abort_region", {28'd0, viol_region}, 32'd0);
        check_eq("abort_type", {30'd0, viol_type}, 32'd0);
        check_eq("abort_dout", {16'd0, mem_dout}, 32'h4444);
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("abort_after", {31'd0, reset}, 32'd0);

`ifdef SMART_MAC_DEBUG_BYPASS_EN
        // Bypass: detection and capture run, but no reset and no masking
        disable_debug = 1'b1;
        drive(16'h0050, 1'b1, 16'h0204, 16'h5555);
        #1 check_eq("byp_dout", {16'd0, mem_dout}, 32'h5555);
        tick();
        check_eq("byp_reset", {31'd0, reset}, 32'd0);
        check_eq("byp_valid", {31'd0, viol_valid}, 32'd1);
        check_eq("byp_count", {24'd0, viol_count}, 32'd1);
        drive(16'h0050, 1'b0, 16'h0000, 16'h0000);
        repeat (4) tick();
        disable_debug = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
